ps2_device_tx: RTL and testbench

PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

---
 rtl/ps2_device_tx.sv | 161 ++++++++++++++++
 tb/tb_ps2_device_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_tx.sv
// PS/2 device-to-host transmitter: waits for an idle bus, clocks out an 11-bit
// frame on open-drain lines and restarts the whole frame if the host inhibits it.
module ps2_device_tx #(
    parameter int NUM_OF_BITS_CLK_HALF_CNT = 3,
    parameter int NUM_OF_BITS_FOR_100US    = 13
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        ps2_clk,
    inout  wire        ps2_data,
    input  logic       ps2_wr_stb,
    input  logic [7:0] ps2_wr_data,
    output logic       ps2_tx_ready,
    output logic       ps2_tx_done,
    output logic       ps2_tx_abort
);

    typedef enum logic [1:0] {IDLE, WAIT_BUS, SEND_H, SEND_L} state_t;

    state_t state, state_nxt;
    logic [1:0] clk_sync, data_sync;
    logic clk_s, data_s;
    logic [NUM_OF_BITS_CLK_HALF_CNT-1:0] half_cnt, half_cnt_nxt;
    logic [NUM_OF_BITS_FOR_100US-1:0]    idle_cnt, idle_cnt_nxt;
    logic [3:0] bit_idx, bit_idx_nxt;
    logic [7:0] data_q, data_q_nxt;
    logic       parity_q, parity_q_nxt;
    logic       clk_oe, clk_oe_nxt, data_oe, data_oe_nxt;
    logic       done_q, done_nxt, abort_q, abort_nxt;

    // Frame bit idx: start 0, data LSB first, odd parity, stop 1.
    function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] d, input logic p);
        if (idx == 4'd0)      return 1'b0;
        else if (idx <= 4'd8) return d[3'(idx - 4'd1)];
        else if (idx == 4'd9) return p;
        else                  return 1'b1;
    endfunction

    assign ps2_clk      = clk_oe  ? 1'b0 : 1'bz;
    assign ps2_data     = data_oe ? 1'b0 : 1'bz;
    assign clk_s        = clk_sync[1];
    assign data_s       = data_sync[1];
    assign ps2_tx_ready = (state == IDLE);
    assign ps2_tx_done  = done_q;
    assign ps2_tx_abort = abort_q;

    // Sync flops reset to the pulled-up idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            half_cnt <= '0;
            idle_cnt <= '0;
            bit_idx  <= '0;
            data_q   <= '0;
            parity_q <= 1'b0;
            clk_oe   <= 1'b0;
            data_oe  <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            half_cnt <= half_cnt_nxt;
            idle_cnt <= idle_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            data_q   <= data_q_nxt;
            parity_q <= parity_q_nxt;
            clk_oe   <= clk_oe_nxt;
            data_oe  <= data_oe_nxt;
            done_q   <= done_nxt;
            abort_q  <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        half_cnt_nxt = half_cnt;
        idle_cnt_nxt = idle_cnt;
        bit_idx_nxt  = bit_idx;
        data_q_nxt   = data_q;
        parity_q_nxt = parity_q;
        clk_oe_nxt   = clk_oe;
        data_oe_nxt  = data_oe;
        done_nxt     = 1'b0;
        abort_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (ps2_wr_stb) begin
                    data_q_nxt   = ps2_wr_data;
                    parity_q_nxt = ~^ps2_wr_data;
                    idle_cnt_nxt = '0;
                    state_nxt    = WAIT_BUS;
                end
            end
            WAIT_BUS: begin
                // A low data line here is also the host's request-to-send.
                if (clk_s && data_s) begin
                    if (idle_cnt == '1) begin
                        state_nxt    = SEND_H;
                        idle_cnt_nxt = '0;
                        half_cnt_nxt = '0;
                        bit_idx_nxt  = 4'd0;
                        clk_oe_nxt   = 1'b0;
                        data_oe_nxt  = ~frame_bit(4'd0, data_q, parity_q);
                    end else begin
                        idle_cnt_nxt = idle_cnt + 1'b1;
                    end
                end else begin
                    idle_cnt_nxt = '0;
                end
            end
            SEND_H: begin
                if (half_cnt == '1) begin
                    half_cnt_nxt = '0;
                    if (!clk_s) begin
                        state_nxt    = WAIT_BUS;
                        idle_cnt_nxt = '0;
                        bit_idx_nxt  = 4'd0;
                        clk_oe_nxt   = 1'b0;
                        data_oe_nxt  = 1'b0;
                        abort_nxt    = 1'b1;
                    end else begin
                        state_nxt  = SEND_L;
                        clk_oe_nxt = 1'b1;
                    end
                end else begin
                    half_cnt_nxt = half_cnt + 1'b1;
                end
            end
            SEND_L: begin
                if (half_cnt == '1) begin
                    half_cnt_nxt = '0;
                    clk_oe_nxt   = 1'b0;
                    if (bit_idx == 4'd10) begin
                        state_nxt   = IDLE;
                        bit_idx_nxt = 4'd0;
                        data_oe_nxt = 1'b0;
                        done_nxt    = 1'b1;
                    end else begin
                        state_nxt   = SEND_H;
                        bit_idx_nxt = bit_idx + 4'd1;
                        data_oe_nxt = ~frame_bit(bit_idx + 4'd1, data_q, parity_q);
                    end
                end else begin
                    half_cnt_nxt = half_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: a host-side receiver decodes frames on falling
// ps2_clk edges and a scoreboard compares them with a reference frame model.
`timescale 1ns/1ps
module tb_ps2_device_tx;
    localparam int HALF = 8;

    logic clk = 1'b0, rst = 1'b1;
    wire  ps2_clk, ps2_data;
    logic stb = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic ready, done, abort;
    logic host_clk_low = 1'b0, host_data_low = 1'b0;

    pullup (ps2_clk);
    pullup (ps2_data);
    assign ps2_clk  = host_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = host_data_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    ps2_device_tx #(.NUM_OF_BITS_CLK_HALF_CNT(3), .NUM_OF_BITS_FOR_100US(5)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ps2_wr_stb(stb), .ps2_wr_data(wdata),
        .ps2_tx_ready(ready), .ps2_tx_done(done), .ps2_tx_abort(abort));

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int rx_n = 0, done_cnt = 0, abort_cnt = 0, fall_total = 0, last_fall = 0;
    logic [10:0] rx_bits = '0;
    logic [10:0] exp_q[$];
    logic prev_clk = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference frame from the protocol rules: start, LSB-first data, odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = b[i];
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out, required event not seen", name);
    endtask

    // Monitor: host-side receiver plus scoreboard pop on every done pulse.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            rx_n = 0;
        end else begin
            if (prev_clk === 1'b1 && ps2_clk === 1'b0 && !host_clk_low) begin
                if (rx_n > 0) check("bit_period", cyc - last_fall, 2 * HALF);
                if (rx_n < 11) rx_bits[rx_n] = ps2_data;
                rx_n++;
                fall_total++;
                last_fall = cyc;
            end
            if (done || abort) check("done_abort_excl", {31'd0, done && abort}, 0);
            if (abort) begin
                abort_cnt++;
                rx_n = 0;
            end
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame: got %0h, want no frame", rx_bits);
                end else begin
                    logic [10:0] e;
                    e = exp_q.pop_front();
                    check("frame_len", rx_n, 11);
                    check("frame_bits", {21'd0, rx_bits}, {21'd0, e});
                end
                rx_n = 0;
            end
        end
        prev_clk = ps2_clk;
    end

    task automatic strobe(input logic [7:0] b);
        @(negedge clk);
        stb = 1'b1;
        wdata = b;
        @(negedge clk);
        stb = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 2000; i++) begin
            if (ready === 1'b1) return;
            @(negedge clk);
        end
        timeout("wait_ready");
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done_cnt > d0) return;
        end
        timeout("wait_done");
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rx_n >= n) return;
        end
        timeout("wait_rx");
    endtask

    task automatic wait_data_low(input int start, output int gap);
        gap = -1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (ps2_data === 1'b0) begin
                gap = cyc - start;
                return;
            end
        end
        timeout("wait_data_low");
    endtask

    task automatic send(input logic [7:0] b);
        int d0;
        wait_ready();
        d0 = done_cnt;
        exp_q.push_back(ref_frame(b));
        strobe(b);
        wait_done(d0);
        @(negedge clk);
        check("ready_after_done", {31'd0, ready}, 1);
    endtask

    initial begin
        int d0, a0, f0, rel, gap;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 1);
        check("rst_done",  {31'd0, done}, 0);
        check("rst_abort", {31'd0, abort}, 0);
        check("rst_clk_z",  {31'd0, ps2_clk}, 1);
        check("rst_data_z", {31'd0, ps2_data}, 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 0xA5 against the literal host-side sample sequence
        wait_ready();
        d0 = done_cnt;
        exp_q.push_back(11'b111_0100_1010);
        strobe(8'hA5);
        check("ready_drop", {31'd0, ready}, 0);
        wait_done(d0);
        @(negedge clk);
        check("a5_done_once", done_cnt - d0, 1);
        check("a5_ready", {31'd0, ready}, 1);

        send(8'h00);
        send(8'h01);
        send(8'hFF);
        for (int i = 0; i < 12; i++) send(8'($urandom_range(255)));

        // host inhibit during the data-bit-5 high phase of 0x3C
        wait_ready();
        d0 = done_cnt;
        a0 = abort_cnt;
        exp_q.push_back(ref_frame(8'h3C));
        strobe(8'h3C);
        wait_rx(6);
        for (int i = 0; i < 40 && ps2_clk !== 1'b1; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        host_clk_low = 1'b1;
        repeat (100) @(negedge clk);
        check("abort_once", abort_cnt - a0, 1);
        check("abort_data_rel", {31'd0, ps2_data}, 1);
        host_clk_low = 1'b0;
        rel = cyc;
        @(negedge clk);
        check("abort_clk_rel", {31'd0, ps2_clk}, 1);
        wait_data_low(rel, gap);
        check_range("retx_gap", gap, 32, 36);
        wait_done(d0);
        @(negedge clk);
        check("abort_done_once", done_cnt - d0, 1);
        check("abort_no_more", abort_cnt - a0, 1);

        // host request-to-send holds the device off
        wait_ready();
        @(negedge clk);
        host_data_low = 1'b1;
        d0 = done_cnt;
        f0 = fall_total;
        wdata = 8'($urandom_range(255));
        exp_q.push_back(ref_frame(wdata));
        strobe(wdata);
        repeat (200) @(negedge clk);
        check("rts_no_clk", fall_total - f0, 0);
        host_data_low = 1'b0;
        rel = cyc;
        @(negedge clk);
        wait_data_low(rel, gap);
        check_range("rts_start_gap", gap, 33, 35);
        wait_done(d0);

        // strobe while busy is ignored
        wait_ready();
        d0 = done_cnt;
        exp_q.push_back(ref_frame(8'h55));
        strobe(8'h55);
        wait_rx(3);
        strobe(8'h77);
        wait_done(d0);
        repeat (300) @(negedge clk);
        check("busy_one_done", done_cnt - d0, 1);
        check("busy_q_empty", exp_q.size(), 0);

        // asynchronous reset mid-frame
        wait_ready();
        exp_q.push_back(ref_frame(8'h00));
        strobe(8'h00);
        wait_rx(4);
        d0 = done_cnt;
        a0 = abort_cnt;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_clk", {31'd0, ps2_clk}, 1);
        check("rst_mid_data", {31'd0, ps2_data}, 1);
        check("rst_mid_ready", {31'd0, ready}, 1);
        exp_q.delete();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_no_abort", abort_cnt - a0, 0);

        send(8'($urandom_range(255)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
